// File: rtl/usb_endpoint_devout_mpbuf.sv
// usb_endpoint_devout_mpbuf: multi-packet IN endpoint buffer.
// Device logic fills whole packets into a circular byte memory; each packet is
// committed or discarded atomically, then served to the host on IN tokens and
// retransmitted until ACKed.
// Optional feature: define USB_EP_HALT_EN to add halt_i (STALL responses).
module usb_endpoint_devout_mpbuf #(
    parameter int ADDR_WID     = 9,
    parameter int MAX_PKT_SIZE = 64,
    parameter int PKT_SLOTS    = 4,
    parameter int EP_TYPE      = 0
) (
    input  logic                           clk12_i,
    input  logic                           rst_n_i,
`ifdef USB_EP_HALT_EN
    input  logic                           halt_i,
`endif
    input  logic                           gotTransStartPacket_i,
    input  logic                           resetDataToggle_i,
    input  logic                           fillTransDone_i,
    input  logic                           fillTransSuccess_i,
    input  logic                           dataValid_i,
    input  logic [7:0]                     data_i,
    output logic                           full_o,
    input  logic                           popData_i,
    output logic [7:0]                     data_o,
    output logic                           dataAvailable_o,
    output logic                           isLastPacketByte_o,
    input  logic                           popTransDone_i,
    input  logic                           popTransSuccess_i,
    output logic                           respValid_o,
    output logic                           respHandshakePID_o,
    output logic [1:0]                     respPacketID_o,
    output logic [$clog2(PKT_SLOTS+1)-1:0] pktCount_o,
    output logic                           overflow_o
);
    localparam int DEPTH  = 2 ** ADDR_WID;
    localparam int PW     = ADDR_WID + 1;
    localparam int LW     = $clog2(MAX_PKT_SIZE + 1);
    localparam int SW     = $clog2(PKT_SLOTS);
    localparam int CW     = $clog2(PKT_SLOTS + 1);
    localparam bit IS_ISO = (EP_TYPE == 2);

    typedef enum logic [1:0] {F_IDLE, F_ACTIVE, F_DROP} fill_state_t;
    typedef enum logic {R_IDLE, R_SEND} rd_state_t;

    fill_state_t f_state, f_next;
    rd_state_t   r_state, r_next;

    logic [7:0]          mem [DEPTH];
    logic [LW-1:0]       len_q [PKT_SLOTS];
    logic [PW-1:0]       wr_ptr_c, wr_ptr_t, rd_ptr_c, used;
    logic [ADDR_WID-1:0] rd_ptr_t, rd_nxt;
    logic [SW:0]         q_head, q_tail;
    logic [LW-1:0]       fill_cnt, rem;
    logic                fetch, toggle, overflow_set;
    logic                halt, halt_fall;
    logic                byte_in, wr_en, rd_free, slot_ok, commit;

`ifdef USB_EP_HALT_EN
    logic halt_q;
    assign halt      = halt_i;
    assign halt_fall = halt_q & ~halt_i;

    // Remember last halt level to detect its release
    always_ff @(posedge clk12_i) begin
        if (!rst_n_i) halt_q <= 1'b0;
        else          halt_q <= halt_i;
    end
`else
    assign halt      = 1'b0;
    assign halt_fall = 1'b0;
`endif

    // Bytes in use are measured against the committed read pointer, so a fill
    // can never overwrite a packet that may still need retransmission.
    assign used        = wr_ptr_t - rd_ptr_c;
    assign pktCount_o  = CW'(q_tail - q_head);
    assign full_o      = (used == PW'(DEPTH)) || (pktCount_o == CW'(PKT_SLOTS));
    assign respValid_o = 1'b1;
    assign isLastPacketByte_o = dataAvailable_o && (rem == LW'(1));
    assign rd_nxt      = rd_ptr_t + ADDR_WID'(1);

    // A fill-done pulse takes precedence over a byte offered in the same cycle.
    assign byte_in = dataValid_i && !full_o && !fillTransDone_i;
    assign wr_en   = byte_in && ((f_state == F_IDLE) ||
                     ((f_state == F_ACTIVE) && (fill_cnt != LW'(MAX_PKT_SIZE))));
    assign rd_free = (r_state == R_SEND) && popTransDone_i && !halt &&
                     (popTransSuccess_i || IS_ISO);
    // A slot freed in this same cycle is available to the commit.
    assign slot_ok = (pktCount_o != CW'(PKT_SLOTS)) || rd_free;
    assign commit  = fillTransDone_i && fillTransSuccess_i && (f_state != F_DROP) && slot_ok;

    // Fill state register
    always_ff @(posedge clk12_i) begin
        if (!rst_n_i) f_state <= F_IDLE;
        else          f_state <= f_next;
    end

    // Fill next state and overflow detection
    always_comb begin
        f_next       = f_state;
        overflow_set = 1'b0;
        case (f_state)
            F_IDLE:   if (byte_in) f_next = F_ACTIVE;
            F_ACTIVE: if (byte_in && (fill_cnt == LW'(MAX_PKT_SIZE))) begin
                          f_next       = F_DROP;
                          overflow_set = 1'b1;
                      end
            F_DROP:   ;
            default:  f_next = F_IDLE;
        endcase
        if (fillTransDone_i) f_next = F_IDLE;
    end

    // Byte memory write port
    always_ff @(posedge clk12_i) begin
        if (wr_en) mem[wr_ptr_t[ADDR_WID-1:0]] <= data_i;
    end

    // Packet length queue write port
    always_ff @(posedge clk12_i) begin
        if (commit) len_q[q_tail[SW-1:0]] <= fill_cnt;
    end

    // Fill pointers: tentative pointer advances per byte, commits or rolls back at done
    always_ff @(posedge clk12_i) begin
        if (!rst_n_i) begin
            wr_ptr_c   <= '0;
            wr_ptr_t   <= '0;
            fill_cnt   <= '0;
            q_tail     <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= overflow_set;
            if (fillTransDone_i) begin
                fill_cnt <= '0;
                if (commit) begin
                    q_tail   <= q_tail + (SW+1)'(1);
                    wr_ptr_c <= wr_ptr_t;
                end else begin
                    wr_ptr_t <= wr_ptr_c;
                end
            end else if (wr_en) begin
                wr_ptr_t <= wr_ptr_t + PW'(1);
                fill_cnt <= fill_cnt + LW'(1);
            end
        end
    end

    // Read state register
    always_ff @(posedge clk12_i) begin
        if (!rst_n_i) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read next state: a token with queued data starts a send
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (gotTransStartPacket_i && (pktCount_o != '0)) r_next = R_SEND;
            R_SEND:  if (popTransDone_i) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
        if (halt) r_next = R_IDLE;
    end

    // Token responses, held until the next token
    always_ff @(posedge clk12_i) begin
        if (!rst_n_i) begin
            respHandshakePID_o <= 1'b1;
            respPacketID_o     <= 2'b10;
        end else if (gotTransStartPacket_i) begin
            if (halt) begin
                respHandshakePID_o <= 1'b1;
                respPacketID_o     <= 2'b11;
            end else if (r_state == R_IDLE) begin
                if (pktCount_o == '0) begin
                    respHandshakePID_o <= 1'b1;
                    respPacketID_o     <= 2'b10;
                end else begin
                    respHandshakePID_o <= 1'b0;
                    respPacketID_o     <= {toggle, 1'b0};
                end
            end
        end
    end

    // Read data path: first-word-fall-through from the head packet
    always_ff @(posedge clk12_i) begin
        if (!rst_n_i) begin
            rd_ptr_c        <= '0;
            rd_ptr_t        <= '0;
            q_head          <= '0;
            rem             <= '0;
            fetch           <= 1'b0;
            dataAvailable_o <= 1'b0;
            data_o          <= '0;
        end else begin
            if (rd_free) begin
                q_head   <= q_head + (SW+1)'(1);
                rd_ptr_c <= rd_ptr_c + PW'(len_q[q_head[SW-1:0]]);
            end
            if ((r_state == R_IDLE) && (r_next == R_SEND)) begin
                rd_ptr_t        <= rd_ptr_c[ADDR_WID-1:0];
                rem             <= len_q[q_head[SW-1:0]];
                fetch           <= 1'b1;
                dataAvailable_o <= 1'b0;
            end else if ((r_state == R_SEND) && (r_next == R_IDLE)) begin
                rd_ptr_t        <= rd_ptr_c[ADDR_WID-1:0];
                fetch           <= 1'b0;
                dataAvailable_o <= 1'b0;
            end else if (fetch) begin
                data_o          <= mem[rd_ptr_t];
                dataAvailable_o <= (rem != '0);
                fetch           <= 1'b0;
            end else if (dataAvailable_o && popData_i) begin
                rd_ptr_t        <= rd_nxt;
                rem             <= rem - LW'(1);
                data_o          <= mem[rd_nxt];
                dataAvailable_o <= (rem != LW'(1));
            end
        end
    end

    // Data toggle: isochronous stays DATA0; explicit resets beat an ACK flip
    always_ff @(posedge clk12_i) begin
        if (!rst_n_i)                            toggle <= 1'b0;
        else if (IS_ISO)                         toggle <= 1'b0;
        else if (resetDataToggle_i || halt_fall) toggle <= 1'b0;
        else if (rd_free)                        toggle <= ~toggle;
    end
endmodule
